// File: rtl/cl_axil_pkg.sv
// Shared AXI-Lite definitions: bus structs, response codes, decode widths.
package cl_axil_pkg;

    localparam int unsigned axil_addr_width_lp   = 32;
    localparam int unsigned axil_data_width_lp   = 32;
    localparam int unsigned axil_window_width_lp = 12;
    localparam int unsigned axil_idx_width_lp    = axil_window_width_lp - 2;

    localparam logic [1:0] axil_resp_okay   = 2'b00;
    localparam logic [1:0] axil_resp_slverr = 2'b10;

    // Master-to-slave bundle (AW, W, B-ready, AR, R-ready), MSB first.
    typedef struct packed {
        logic [31:0] awaddr;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } bsg_axil_mosi_bus_s;

    // Slave-to-master bundle (readys, B and R channels), MSB first.
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } bsg_axil_miso_bus_s;

    localparam int unsigned axil_mosi_bus_width_lp = $bits(bsg_axil_mosi_bus_s);
    localparam int unsigned axil_miso_bus_width_lp = $bits(bsg_axil_miso_bus_s);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // True when a decoded register index addresses an implemented register.
    function automatic logic idx_in_range(input logic [axil_idx_width_lp-1:0] idx,
                                          input int unsigned num);
        return (32'(idx) < num);
    endfunction

endpackage

// File: rtl/cl_axil_reg_bank.sv
// Register storage with a byte-strobed write port, an asynchronous read
// port and a one-cycle write pulse per register.
module cl_axil_reg_bank
    import cl_axil_pkg::*;
#(
    parameter int unsigned num_regs_p      = 8,
    parameter logic [31:0] reg_reset_val_p = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic [axil_idx_width_lp-1:0] index_i,
    input  logic [31:0]                  data_i,
    input  logic [3:0]                   strb_i,
    input  logic [axil_idx_width_lp-1:0] rd_index_i,
    output logic [31:0]                  rd_data_o,
    output logic [num_regs_p*32-1:0]     regs_o,
    output logic [num_regs_p-1:0]        wr_pulse_o
);

    logic [31:0]           regs_q [num_regs_p];
    logic [num_regs_p-1:0] pulse_q;
    logic [31:0]           rd_data_s;

    // Storage update: strobed bytes of the addressed register, plus its pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(num_regs_p); i++) begin
                regs_q[i] <= reg_reset_val_p;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(num_regs_p); i++) begin
                pulse_q[i] <= en_i && (index_i == axil_idx_width_lp'(i));
                if (en_i && (index_i == axil_idx_width_lp'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb_i[b]) begin
                            regs_q[i][8*b +: 8] <= data_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux: one-hot select, unimplemented indices read as zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        for (int i = 0; i < int'(num_regs_p); i++) begin
            rd_data_s |= (rd_index_i == axil_idx_width_lp'(i)) ? regs_q[i] : 32'h0000_0000;
        end
    end

    assign rd_data_o  = rd_data_s;
    assign wr_pulse_o = pulse_q;

    for (genvar g = 0; g < int'(num_regs_p); g++) begin : g_flat
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: rtl/cl_axil_slv_regfile.sv
// AXI-Lite slave register file: independent write and read FSMs in front of
// a register bank; out-of-range indices answer SLVERR.
module cl_axil_slv_regfile
    import cl_axil_pkg::*;
#(
    parameter int unsigned num_regs_p            = 8,
    parameter logic [31:0] reg_reset_val_p       = 32'h0000_0000,
    parameter int unsigned slv_mosi_bus_width_lp = axil_mosi_bus_width_lp,
    parameter int unsigned slv_miso_bus_width_lp = axil_miso_bus_width_lp
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [slv_mosi_bus_width_lp-1:0] slv_bus_i,
    output logic [slv_miso_bus_width_lp-1:0] slv_bus_o,
    output logic [num_regs_p*32-1:0]         regs_o,
    output logic [num_regs_p-1:0]            wr_pulse_o
);

    localparam int unsigned iw_lp = axil_idx_width_lp;

    bsg_axil_mosi_bus_s mosi_s;
    bsg_axil_miso_bus_s miso_s;
    assign mosi_s = slv_bus_i;

    // Write-path state
    wr_state_e         w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [iw_lp-1:0]  awidx_q, awidx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic [1:0]        bresp_q, bresp_d;
    // Read-path state
    rd_state_e         r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_en_s;
    logic [iw_lp-1:0]  wr_idx_s, rd_idx_s;
    logic [31:0]       wr_data_s, rd_bank_s;
    logic [3:0]        wr_strb_s;
    logic              wr_in_range_s, rd_in_range_s;
    logic              unused_bits_s;

    assign aw_hs_s  = mosi_s.awvalid & awready_q;
    assign w_hs_s   = mosi_s.wvalid & wready_q;
    assign ar_hs_s  = mosi_s.arvalid & arready_q;

    // A channel captured earlier takes priority over the live bus value.
    assign wr_idx_s  = aw_got_q ? awidx_q : mosi_s.awaddr[axil_window_width_lp-1:2];
    assign wr_data_s = w_got_q ? wdata_q : mosi_s.wdata;
    assign wr_strb_s = w_got_q ? wstrb_q : mosi_s.wstrb;
    assign rd_idx_s  = mosi_s.araddr[axil_window_width_lp-1:2];

    assign wr_in_range_s = idx_in_range(wr_idx_s, num_regs_p);
    assign rd_in_range_s = idx_in_range(rd_idx_s, num_regs_p);
    assign commit_s = (w_state_q == W_IDLE) & (aw_got_q | aw_hs_s) & (w_got_q | w_hs_s);

    assign unused_bits_s = ^{mosi_s.awprot, mosi_s.arprot,
                             mosi_s.awaddr[31:axil_window_width_lp], mosi_s.awaddr[1:0],
                             mosi_s.araddr[31:axil_window_width_lp], mosi_s.araddr[1:0]};

    // Write FSM next state: capture AW/W independently, commit when both are in.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bresp_d   = bresp_q;
        wr_en_s   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_got_d = 1'b1;
                    awidx_d  = mosi_s.awaddr[axil_window_width_lp-1:2];
                end else begin
                    aw_got_d = aw_got_q;
                end
                if (w_hs_s) begin
                    w_got_d = 1'b1;
                    wdata_d = mosi_s.wdata;
                    wstrb_d = mosi_s.wstrb;
                end else begin
                    w_got_d = w_got_q;
                end
                if (commit_s) begin
                    wr_en_s   = wr_in_range_s;
                    bresp_d   = wr_in_range_s ? axil_resp_okay : axil_resp_slverr;
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = ~(aw_got_q | aw_hs_s);
                    wready_d  = ~(w_got_q | w_hs_s);
                end
            end
            W_RESP: begin
                if (mosi_s.bready) begin
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b0;
                wready_d  = 1'b0;
            end
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read FSM next state: latch data on AR, hold it until R completes.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    if (rd_in_range_s) begin
                        rdata_d = rd_bank_s;
                        rresp_d = axil_resp_okay;
                    end else begin
                        rdata_d = 32'h0000_0000;
                        rresp_d = axil_resp_slverr;
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (mosi_s.rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                end else begin
                    arready_d = 1'b0;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b0;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    cl_axil_reg_bank #(
        .num_regs_p      (num_regs_p),
        .reg_reset_val_p (reg_reset_val_p)
    ) u_bank (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (wr_en_s),
        .index_i    (wr_idx_s),
        .data_i     (wr_data_s),
        .strb_i     (wr_strb_s),
        .rd_index_i (rd_idx_s),
        .rd_data_o  (rd_bank_s),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    assign miso_s.awready = awready_q;
    assign miso_s.wready  = wready_q;
    assign miso_s.bresp   = bresp_q;
    assign miso_s.bvalid  = (w_state_q == W_RESP);
    assign miso_s.arready = arready_q;
    assign miso_s.rdata   = rdata_q;
    assign miso_s.rresp   = rresp_q;
    assign miso_s.rvalid  = (r_state_q == R_DATA);
    assign slv_bus_o      = miso_s;

endmodule
